// File: rtl/pad_pwr_seq.sv
// +----------------------------------------------------------------------------+
// | pad_pwr_seq : ordered power-up/down sequencer for NUM_DOM supply pads      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pad_pwr_seq #(
   parameter int unsigned NUM_DOM = 4,
   parameter int unsigned DLY_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pwr_req_i,
   input  logic [NUM_DOM*DLY_W-1:0] dly_cfg_i,
   input  logic [NUM_DOM-1:0]       dom_good_i,
   input  logic                     fault_clr_i,
   output logic [NUM_DOM-1:0]       dom_en_o,
   output logic                     pwr_good_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      UP_WAIT   = 3'd1,
      ON        = 3'd2,
      DOWN_WAIT = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DLY_W-1:0]     cnt_q, cnt_d;
   logic [NUM_DOM-1:0]   dom_en_q, dom_en_d;
   logic                 pwr_good_q, busy_q, err_q;

   logic [DLY_W-1:0]     w_dly [NUM_DOM];
   logic [IDX_W-1:0]     w_idx_inc, w_idx_dec;

   for (genvar g = 0; g < NUM_DOM; g++) begin : g_dly
      assign w_dly[g] = dly_cfg_i[g*DLY_W +: DLY_W];
   end

   assign w_idx_inc = idx_q + 1'b1;
   assign w_idx_dec = idx_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      dom_en_d = dom_en_q;
      case (state_q)
         IDLE: begin
            if (pwr_req_i) begin
               dom_en_d = NUM_DOM'(1);
               idx_d    = '0;
               cnt_d    = w_dly[0];
               state_d  = UP_WAIT;
            end
         end
         UP_WAIT: begin
            // Withdrawal of the request overrides any pending settle check.
            if (!pwr_req_i) begin
               dom_en_d = dom_en_q & ~(NUM_DOM'(1) << idx_q);
               cnt_d    = w_dly[idx_q];
               state_d  = DOWN_WAIT;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!dom_good_i[idx_q]) begin
               dom_en_d = '0;
               state_d  = FAULT;
            end else if (idx_q == LAST_IDX) begin
               state_d = ON;
            end else begin
               idx_d    = w_idx_inc;
               dom_en_d = dom_en_q | (NUM_DOM'(1) << w_idx_inc);
               cnt_d    = w_dly[w_idx_inc];
            end
         end
         ON: begin
            if (!pwr_req_i) begin
               idx_d    = LAST_IDX;
               dom_en_d = dom_en_q & ~(NUM_DOM'(1) << LAST_IDX);
               cnt_d    = w_dly[LAST_IDX];
               state_d  = DOWN_WAIT;
            end else if (!(&dom_good_i)) begin
               dom_en_d = '0;
               state_d  = FAULT;
            end
         end
         DOWN_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q != '0) begin
               idx_d    = w_idx_dec;
               dom_en_d = dom_en_q & ~(NUM_DOM'(1) << w_idx_dec);
               cnt_d    = w_dly[w_idx_dec];
            end else begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (fault_clr_i && !pwr_req_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            dom_en_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         dom_en_q   <= '0;
         pwr_good_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         dom_en_q   <= dom_en_d;
         pwr_good_q <= (state_d == ON);
         busy_q     <= (state_d == UP_WAIT) || (state_d == DOWN_WAIT);
         err_q      <= (state_d == FAULT);
      end
   end

   assign dom_en_o   = dom_en_q;
   assign pwr_good_o = pwr_good_q;
   assign busy_o     = busy_q;
   assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pad_pwr_seq.sv
// +----------------------------------------------------------------------------+
// | tb_pad_pwr_seq : directed self-checking bench for pad_pwr_seq              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pad_pwr_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pwr_req;
   logic [31:0] dly_cfg;
   logic [3:0]  dom_good;
   logic        fault_clr;
   logic [3:0]  dom_en;
   logic        pwr_good, busy, err;
   logic [3:0]  good_mask;
   logic [6:0]  obs;
   int          vectors    = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   // Healthy pads report good exactly where enabled; good_mask injects failures.
   assign dom_good = dom_en & good_mask;
   assign obs      = {dom_en, pwr_good, busy, err};

   pad_pwr_seq #(.NUM_DOM(4), .DLY_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwr_req_i  (pwr_req),
      .dly_cfg_i  (dly_cfg),
      .dom_good_i (dom_good),
      .fault_clr_i(fault_clr),
      .dom_en_o   (dom_en),
      .pwr_good_o (pwr_good),
      .busy_o     (busy),
      .err_o      (err)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // obs = {dom_en[3:0], pwr_good, busy, err}
   task automatic test_reset();
      rst_n = 1'b0; pwr_req = 1'b0; fault_clr = 1'b0; good_mask = 4'hF; dly_cfg = '0;
      #2;
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL reset_async: got %b want %b", obs, 7'b0000_000); end
      step(2);
      rst_n = 1'b1;
      step(3);
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL reset_idle_hold: got %b want %b", obs, 7'b0000_000); end
   endtask

   task automatic test_power_up();
      dly_cfg = {4{8'd2}}; good_mask = 4'hF;
      pwr_req = 1'b1;
      step(1); // edge E
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL up_E: got %b want %b", obs, 7'b0001_010); end
      dly_cfg[7:0] = 8'd9; // already loaded, must not matter
      step(2);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL up_E2: got %b want %b", obs, 7'b0001_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0011_010) begin miscompares++; $display("FAIL up_E3: got %b want %b", obs, 7'b0011_010); end
      step(3);
      vectors++;
      if (obs !== 7'b0111_010) begin miscompares++; $display("FAIL up_E6: got %b want %b", obs, 7'b0111_010); end
      step(3);
      vectors++;
      if (obs !== 7'b1111_010) begin miscompares++; $display("FAIL up_E9: got %b want %b", obs, 7'b1111_010); end
      step(2);
      vectors++;
      if (obs !== 7'b1111_010) begin miscompares++; $display("FAIL up_E11: got %b want %b", obs, 7'b1111_010); end
      step(1);
      vectors++;
      if (obs !== 7'b1111_100) begin miscompares++; $display("FAIL up_E12_on: got %b want %b", obs, 7'b1111_100); end
   endtask

   task automatic test_power_down();
      dly_cfg = {4{8'd1}};
      pwr_req = 1'b0;
      step(1); // edge F
      vectors++;
      if (obs !== 7'b0111_010) begin miscompares++; $display("FAIL down_F: got %b want %b", obs, 7'b0111_010); end
      step(2);
      vectors++;
      if (obs !== 7'b0011_010) begin miscompares++; $display("FAIL down_F2: got %b want %b", obs, 7'b0011_010); end
      pwr_req = 1'b1; // ignored until back in IDLE
      step(2);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL down_F4: got %b want %b", obs, 7'b0001_010); end
      step(2);
      vectors++;
      if (obs !== 7'b0000_010) begin miscompares++; $display("FAIL down_F6: got %b want %b", obs, 7'b0000_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0000_010) begin miscompares++; $display("FAIL down_F7: got %b want %b", obs, 7'b0000_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL down_F8_idle: got %b want %b", obs, 7'b0000_000); end
      step(1);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL down_rerequest: got %b want %b", obs, 7'b0001_010); end
      pwr_req = 1'b0;
      step(4);
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL down_reabort_idle: got %b want %b", obs, 7'b0000_000); end
   endtask

   task automatic test_bad_supply();
      dly_cfg = '0; good_mask = 4'b1011;
      pwr_req = 1'b1;
      step(1);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL bad_E: got %b want %b", obs, 7'b0001_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0011_010) begin miscompares++; $display("FAIL bad_E1_zero_dly: got %b want %b", obs, 7'b0011_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0111_010) begin miscompares++; $display("FAIL bad_E2: got %b want %b", obs, 7'b0111_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0000_001) begin miscompares++; $display("FAIL bad_fault: got %b want %b", obs, 7'b0000_001); end
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      vectors++;
      if (obs !== 7'b0000_001) begin miscompares++; $display("FAIL bad_clr_ignored: got %b want %b", obs, 7'b0000_001); end
      pwr_req = 1'b0;
      step(1);
      vectors++;
      if (obs !== 7'b0000_001) begin miscompares++; $display("FAIL bad_no_clr_hold: got %b want %b", obs, 7'b0000_001); end
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL bad_clr_idle: got %b want %b", obs, 7'b0000_000); end
      good_mask = 4'hF;
   endtask

   task automatic test_abort();
      dly_cfg = {4{8'd3}};
      pwr_req = 1'b1;
      step(5); // E+4
      vectors++;
      if (obs !== 7'b0011_010) begin miscompares++; $display("FAIL abort_E4: got %b want %b", obs, 7'b0011_010); end
      step(1);
      pwr_req = 1'b0;
      step(1); // abort edge A
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL abort_A: got %b want %b", obs, 7'b0001_010); end
      step(3);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL abort_A3: got %b want %b", obs, 7'b0001_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0000_010) begin miscompares++; $display("FAIL abort_A4: got %b want %b", obs, 7'b0000_010); end
      step(4);
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL abort_idle: got %b want %b", obs, 7'b0000_000); end
   endtask

   task automatic test_brown_out();
      dly_cfg = '0; good_mask = 4'hF;
      pwr_req = 1'b1;
      step(5);
      vectors++;
      if (obs !== 7'b1111_100) begin miscompares++; $display("FAIL brown_on: got %b want %b", obs, 7'b1111_100); end
      good_mask = 4'b1101;
      step(1);
      good_mask = 4'hF;
      vectors++;
      if (obs !== 7'b0000_001) begin miscompares++; $display("FAIL brown_fault: got %b want %b", obs, 7'b0000_001); end
      pwr_req = 1'b0; fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL brown_clr: got %b want %b", obs, 7'b0000_000); end
   endtask

   task automatic test_reset_mid();
      dly_cfg = {4{8'd255}};
      pwr_req = 1'b1;
      step(1);
      step(255);
      vectors++;
      if (obs !== 7'b0001_010) begin miscompares++; $display("FAIL maxdly_E255: got %b want %b", obs, 7'b0001_010); end
      step(1);
      vectors++;
      if (obs !== 7'b0011_010) begin miscompares++; $display("FAIL maxdly_E256: got %b want %b", obs, 7'b0011_010); end
      step(356);
      vectors++;
      if (obs !== 7'b0111_010) begin miscompares++; $display("FAIL maxdly_mid: got %b want %b", obs, 7'b0111_010); end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL reset_mid_async: got %b want %b", obs, 7'b0000_000); end
      pwr_req = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(2);
      vectors++;
      if (obs !== 7'b0000_000) begin miscompares++; $display("FAIL reset_mid_after: got %b want %b", obs, 7'b0000_000); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_power_down();
      test_bad_supply();
      test_abort();
      test_brown_out();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
